src_control_unit: RTL
=====================

// Module: src_control_unit
// PURPOSE
//  Hardwired control FSM for the Mini SRC datapath. Sequences fetch (T0-T2) and per-class execute steps.
//  Drives every bus-source enable, register load, ALU op select and memory strobe of the datapath, one step per clock.
//  Sits beside the datapath top level. Its outputs connect 1:1 to the datapath control inputs.
//  The IR contents return to it via ir[31:0].
// PARAMETERS
//  OPW      5   opcode field width, IR[31:27]
//  ALUW     4   alu_op output width, matches the datapath opcode input
//  RST_PC   0   informational only; PC reset value is owned by the PC register
// PORTS
//  clock      in   1   rising-edge clock
//  clear      in   1   asynchronous, active-low reset
//  run_req    in   1   level; 1 = execute, 0 = pause at next fetch boundary
//  ir         in   32  IR contents: op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//  mem_ready  in   1   memory access complete, sampled in wait steps
//  PCout Zhiout Zloout MDRout Cout BAout Rout  out 1  bus-source enables (one-hot or none)
//  MARin PCin MDRin IRin Yin Zin Rin HIin LOin out 1  register load enables
//  IncPC Read Write                            out 1  PC increment and memory strobes
//  Gra Grb Grc     out  1   register-field select for Rin/Rout decode
//  alu_op          out  ALUW  ALU operation; ALU_ADD when not in an ALU step
//  run             out  1   1 while not HALTED/PAUSED
//  illegal         out  1   1-cycle pulse when an unsupported opcode is decoded
// BEHAVIOUR
//  Reset (clear=0): state=T0, all outputs 0, alu_op=ALU_ADD, run=0. Effect is immediate (async).
//  Reset mid-instruction abandons that instruction. No strobe is held across reset.
//  Outputs are Moore, decoded from state and the latched opcode.
//  Never more than one bus-source enable is high per cycle; assertions must check this.
//  Fetch:
//   T0: PCout MARin IncPC Zin
//   T1: Zloout PCin Read MDRin; hold T1 while mem_ready=0
//   T2: MDRout IRin
//  T3 latches ir[31:27] into op_q. Decode uses op_q only.
//  ALU reg (add sub and or shr shra shl ror rol):
//   T3: Grb Rout Yin; T4: Grc Rout alu_op Zin; T5: Zloout Gra Rin -> T0
//  Immediate (addi andi ori):
//   T3: Grb Rout Yin; T4: Cout alu_op Zin; T5: Zloout Gra Rin -> T0
//  ldi:
//   T3: Grb BAout Yin; T4: Cout ADD Zin; T5: Zloout Gra Rin -> T0
//  ld: as ldi T3-T4, then:
//   T5: Zloout MARin; T6: Read MDRin, hold while !mem_ready; T7: MDRout Gra Rin -> T0
//  st: as ldi T3-T4, then:
//   T5: Zloout MARin; T6: Gra Rout MDRin; T7: Write, hold while !mem_ready -> T0
//  jr:   T3: Gra Rout PCin -> T0
//  nop:  T3 -> T0
//  halt: T3 -> HALTED. run=0; exits only on reset.
//  Unsupported opcode: illegal=1 in T3, then executes as nop.
//  Pause: run_req=0 is sampled only in T0. FSM goes to PAUSED with all strobes 0.
//   From PAUSED it re-enters T0 the cycle after run_req=1. Pause never occurs mid-instruction.
//  Memory waits have no timeout. Read and Write stay high for the whole wait.
//  The wait step exits on the first cycle mem_ready=1.
//  Step counter wraps only via explicit -> T0 transitions. Unreachable state codes go to T0.
// CONFIGURATION
//  SRC_MULDIV_EN defined: mul/div are supported.
//   T3: Gra Rout Yin; T4: Grb Rout alu_op(MUL|DIV) Zin; T5: Zloout LOin; T6: Zhiout HIin -> T0
//  SRC_MULDIV_EN undefined: mul/div raise illegal and execute as nop. HIin, LOin and Zhiout are tied 0.
// STRUCTURE
//  Package src_ctrl_pkg holds:
//   opcode localparams (ld=00000 ldi=00001 st=00010 add=00011 sub=00100 and=00101
//    or=00110 ror=00111 rol=01000 shr=01001 shra=01010 shl=01011 addi=01100 andi=01101
//    ori=01110 div=01111 mul=10000 jr=10100 nop=11010 halt=11011)
//   ALU_* op codes, shared with the alu
//   step/state encodings T0..T7, PAUSED, HALTED
//  One natural sub-module: src_op_decode (combinational).
//   Maps op_q to class {ALU, IMM, LDI, LD, ST, JR, MULDIV, NOP, HALT, ILLEGAL} and alu_op.
// TESTING
//  1. clear=0 mid-T4 of add -> all strobes 0 same cycle; after release, PCout+MARin+IncPC+Zin in first cycle.
//  2. ir=add R1,R2,R3 (0x18918000), mem_ready=1 -> T0..T5 in 6 cycles;
//     T4 shows Grc Rout Zin, alu_op=ALU_ADD; T5 shows Zloout Gra Rin.
//  3. ld with mem_ready low 3 cycles in T1 and 2 cycles in T6 -> Read held each wait; total 8+5=13 cycles.
//  4. st R1,0x10(R2) -> T6 Gra Rout MDRin; T7 Write, held until mem_ready; no Read asserted.
//  5. opcode 11111 -> illegal pulse in T3, next cycle T0; halt -> run=0, stuck until clear.
//  6. mul with and without SRC_MULDIV_EN -> LOin in T5 and HIin in T6 vs illegal pulse, HIin/LOin never 1.
//     Also: run_req=0 mid-instruction -> instruction completes, then PAUSED.

Source files
------------

// File: rtl/src_control_unit_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, ALU op codes,
// step/state encodings, decoded instruction classes and the registered control word.
package src_ctrl_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned ALUW = 4;
    localparam int unsigned IRW  = 32;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [ALUW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUW-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUW-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUW-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUW-1:0] ALU_SHR  = 4'd4;
    localparam logic [ALUW-1:0] ALU_SHRA = 4'd5;
    localparam logic [ALUW-1:0] ALU_SHL  = 4'd6;
    localparam logic [ALUW-1:0] ALU_ROR  = 4'd7;
    localparam logic [ALUW-1:0] ALU_ROL  = 4'd8;
    localparam logic [ALUW-1:0] ALU_MUL  = 4'd9;
    localparam logic [ALUW-1:0] ALU_DIV  = 4'd10;

    typedef enum logic [3:0] {
        ST_T0     = 4'd0,
        ST_T1     = 4'd1,
        ST_T2     = 4'd2,
        ST_T3     = 4'd3,
        ST_T4     = 4'd4,
        ST_T5     = 4'd5,
        ST_T6     = 4'd6,
        ST_T7     = 4'd7,
        ST_PAUSED = 4'd8,
        ST_HALTED = 4'd9
    } step_e;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_JR, CL_MULDIV, CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic            pc_out;
        logic            zhi_out;
        logic            zlo_out;
        logic            mdr_out;
        logic            c_out;
        logic            ba_out;
        logic            r_out;
        logic            mar_in;
        logic            pc_in;
        logic            mdr_in;
        logic            ir_in;
        logic            y_in;
        logic            z_in;
        logic            r_in;
        logic            hi_in;
        logic            lo_in;
        logic            inc_pc;
        logic            read;
        logic            write;
        logic            gra;
        logic            grb;
        logic            grc;
        logic [ALUW-1:0] alu_op;
        logic            run;
        logic            illegal;
    } ctrl_t;

    // Quiescent control word: no strobes, ALU parked on add, not running.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/src_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/handshake inputs and every datapath control strobe.
interface src_control_unit_if;
    import src_ctrl_pkg::*;

    logic            run_req;
    logic [IRW-1:0]  ir;
    logic            mem_ready;

    logic PCout, Zhiout, Zloout, MDRout, Cout, BAout, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin;
    logic IncPC, Read, Write;
    logic Gra, Grb, Grc;
    logic [ALUW-1:0] alu_op;
    logic run;
    logic illegal;

    modport master (
        input  run_req, ir, mem_ready,
        output PCout, Zhiout, Zloout, MDRout, Cout, BAout, Rout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
        output IncPC, Read, Write, Gra, Grb, Grc, alu_op, run, illegal
    );

    modport slave (
        output run_req, ir, mem_ready,
        input  PCout, Zhiout, Zloout, MDRout, Cout, BAout, Rout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
        input  IncPC, Read, Write, Gra, Grb, Grc, alu_op, run, illegal
    );

endinterface

// File: rtl/src_control_unit_op_decode.sv
// Combinational opcode classifier: instruction class and ALU operation for an opcode.
// mul/div are recognised only when SRC_MULDIV_EN is defined; otherwise they are illegal.
module src_op_decode
    import src_ctrl_pkg::*;
(
    input  logic [OPW-1:0]  op_i,
    output op_class_e       op_class_c_o,
    output logic [ALUW-1:0] alu_op_c_o
);

    always_comb begin
        op_class_c_o = CL_ILLEGAL;
        alu_op_c_o   = ALU_ADD;
        case (op_i)
            OP_ADD:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_ADD;  end
            OP_SUB:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_SUB;  end
            OP_AND:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_AND;  end
            OP_OR:   begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_OR;   end
            OP_SHR:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_SHR;  end
            OP_SHRA: begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_SHRA; end
            OP_SHL:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_SHL;  end
            OP_ROR:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_ROR;  end
            OP_ROL:  begin op_class_c_o = CL_ALU; alu_op_c_o = ALU_ROL;  end
            OP_ADDI: begin op_class_c_o = CL_IMM; alu_op_c_o = ALU_ADD;  end
            OP_ANDI: begin op_class_c_o = CL_IMM; alu_op_c_o = ALU_AND;  end
            OP_ORI:  begin op_class_c_o = CL_IMM; alu_op_c_o = ALU_OR;   end
            OP_LDI:  op_class_c_o = CL_LDI;
            OP_LD:   op_class_c_o = CL_LD;
            OP_ST:   op_class_c_o = CL_ST;
            OP_JR:   op_class_c_o = CL_JR;
            OP_NOP:  op_class_c_o = CL_NOP;
            OP_HALT: op_class_c_o = CL_HALT;
`ifdef SRC_MULDIV_EN
            OP_MUL:  begin op_class_c_o = CL_MULDIV; alu_op_c_o = ALU_MUL; end
            OP_DIV:  begin op_class_c_o = CL_MULDIV; alu_op_c_o = ALU_DIV; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/src_control_unit.sv
// Mini SRC hardwired control FSM: fetch T0-T2 then per-class execute steps, one step per clock.
// Define SRC_MULDIV_EN to enable mul/div sequencing (HIin/LOin/Zhiout stay 0 otherwise).
module src_control_unit
    import src_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    src_control_unit_if.master bus
);

    step_e           state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            go_q;
    ctrl_t           ctrl_q, ctrl_d;
    op_class_e       op_class;
    logic [ALUW-1:0] dec_alu_op;
    logic            unused_ir;

    // Opcode is captured as the FSM enters T3 and held for the rest of the instruction.
    assign op_d      = (state_q == ST_T2) ? bus.ir[IRW-1:IRW-OPW] : op_q;
    assign unused_ir = ^bus.ir[IRW-OPW-1:0];

    src_op_decode u_decode (
        .op_i         (op_d),
        .op_class_c_o (op_class),
        .alu_op_c_o   (dec_alu_op)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_T0;
            op_q    <= OP_NOP;
            go_q    <= 1'b0;
            ctrl_q  <= ctrl_idle();
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            go_q    <= 1'b1;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next step, then the control word for that step (registered so outputs track state_q).
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_idle();

        case (state_q)
            ST_T0:     state_d = bus.run_req ? ST_T1 : ST_PAUSED;
            ST_T1:     if (bus.mem_ready) state_d = ST_T2;
            ST_T2:     state_d = ST_T3;
            ST_T3: begin
                case (op_class)
                    CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV: state_d = ST_T4;
                    CL_HALT: state_d = ST_HALTED;
                    default: state_d = ST_T0;
                endcase
            end
            ST_T4:     state_d = ST_T5;
            ST_T5:     state_d = (op_class inside {CL_LD, CL_ST, CL_MULDIV}) ? ST_T6 : ST_T0;
            ST_T6: begin
                if (op_class == CL_LD)      state_d = bus.mem_ready ? ST_T7 : ST_T6;
                else if (op_class == CL_ST) state_d = ST_T7;
                else                        state_d = ST_T0;
            end
            ST_T7:     state_d = (op_class == CL_ST && !bus.mem_ready) ? ST_T7 : ST_T0;
            ST_PAUSED: if (bus.run_req) state_d = ST_T0;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_T0;
        endcase

        // First clock after reset presents T0 before any stepping.
        if (!go_q) state_d = ST_T0;

        ctrl_d.run = (state_d != ST_PAUSED) && (state_d != ST_HALTED);

        case (state_d)
            ST_T0: begin
                ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; ctrl_d.z_in = 1'b1;
            end
            ST_T1: begin
                ctrl_d.zlo_out = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CL_ALU, CL_IMM: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin
                        ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1;
                    end
                    CL_JR:      begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
`ifdef SRC_MULDIV_EN
                    CL_MULDIV:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
`endif
                    CL_ILLEGAL: ctrl_d.illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                ctrl_d.z_in   = 1'b1;
                ctrl_d.alu_op = dec_alu_op;
                case (op_class)
                    CL_ALU:    begin ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; end
                    CL_MULDIV: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; end
                    default:   ctrl_d.c_out = 1'b1;
                endcase
            end
            ST_T5: begin
                ctrl_d.zlo_out = 1'b1;
                case (op_class)
                    CL_LD, CL_ST: ctrl_d.mar_in = 1'b1;
`ifdef SRC_MULDIV_EN
                    CL_MULDIV:    ctrl_d.lo_in  = 1'b1;
`endif
                    default: begin ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
                endcase
            end
            ST_T6: begin
                case (op_class)
                    CL_LD: begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
                    CL_ST: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
`ifdef SRC_MULDIV_EN
                    CL_MULDIV: begin ctrl_d.zhi_out = 1'b1; ctrl_d.hi_in = 1'b1; end
`endif
                    default: ;
                endcase
            end
            ST_T7: begin
                if (op_class == CL_ST) begin
                    ctrl_d.write = 1'b1;
                end else begin
                    ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.PCout   = ctrl_q.pc_out;
    assign bus.Zhiout  = ctrl_q.zhi_out;
    assign bus.Zloout  = ctrl_q.zlo_out;
    assign bus.MDRout  = ctrl_q.mdr_out;
    assign bus.Cout    = ctrl_q.c_out;
    assign bus.BAout   = ctrl_q.ba_out;
    assign bus.Rout    = ctrl_q.r_out;
    assign bus.MARin   = ctrl_q.mar_in;
    assign bus.PCin    = ctrl_q.pc_in;
    assign bus.MDRin   = ctrl_q.mdr_in;
    assign bus.IRin    = ctrl_q.ir_in;
    assign bus.Yin     = ctrl_q.y_in;
    assign bus.Zin     = ctrl_q.z_in;
    assign bus.Rin     = ctrl_q.r_in;
    assign bus.HIin    = ctrl_q.hi_in;
    assign bus.LOin    = ctrl_q.lo_in;
    assign bus.IncPC   = ctrl_q.inc_pc;
    assign bus.Read    = ctrl_q.read;
    assign bus.Write   = ctrl_q.write;
    assign bus.Gra     = ctrl_q.gra;
    assign bus.Grb     = ctrl_q.grb;
    assign bus.Grc     = ctrl_q.grc;
    assign bus.alu_op  = ctrl_q.alu_op;
    assign bus.run     = ctrl_q.run;
    assign bus.illegal = ctrl_q.illegal;

    // The shared bus tolerates at most one driver per cycle.
    bus_src_onehot_a: assert property (@(posedge clock) disable iff (!clear)
        $onehot0({ctrl_q.pc_out, ctrl_q.zhi_out, ctrl_q.zlo_out, ctrl_q.mdr_out,
                  ctrl_q.c_out, ctrl_q.ba_out, ctrl_q.r_out}));

endmodule
